// File: rtl/state_enc_pkg.sv
// ============================================================================
//  Module   : state_enc_pkg
//  Purpose  : AES-128 controller definitions: state codes, round count,
//             round-constant seed and the GF(2^8) xtime helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package state_enc_pkg;

    // Code 3'b110 is KEY in the forward controller; the inverse controller
    // reuses the same encoding for its INV state.
    typedef enum logic [2:0] {
        S_RES = 3'b000,
        S_STL = 3'b001,
        S_ADD = 3'b010,
        S_SUB = 3'b011,
        S_SHI = 3'b100,
        S_MIX = 3'b101,
        S_KEY = 3'b110,
        S_FIN = 3'b111
    } state_t;

    localparam int unsigned AES_NR    = 10;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage : state_enc_pkg

`default_nettype wire

// File: rtl/state_enc_if.sv
// ============================================================================
//  Module   : state_enc_if
//  Purpose  : Host handshake and datapath-control bundle of the AES-128
//             forward-cipher controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface state_enc_if;

    logic       start;
    logic [2:0] cs;
    logic [7:0] cot;
    logic [7:0] rcon;
    logic       busy;
    logic       done;

    // The host side launches blocks and observes progress.
    modport master (
        output start,
        input  cs,
        input  cot,
        input  rcon,
        input  busy,
        input  done
    );

    // The controller side.
    modport slave (
        input  start,
        output cs,
        output cot,
        output rcon,
        output busy,
        output done
    );

endinterface : state_enc_if

`default_nettype wire

// File: rtl/state_enc_rcon_gen.sv
// ============================================================================
//  Module   : aes_rcon_gen
//  Purpose  : AES key-schedule round-constant register: reload to 0x01,
//             advance by xtime, asynchronous reset to 0x01.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rcon_gen
    import state_enc_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       res,
    input  wire logic       load_i,
    input  wire logic       adv_i,
    output      logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    // Load has priority so a new block always starts from the seed.
    always_comb begin
        rcon_d = rcon_q;
        if (load_i) begin
            rcon_d = RCON_INIT;
        end else if (adv_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule : aes_rcon_gen

`default_nettype wire

// File: rtl/state_enc.sv
// ============================================================================
//  Module   : state_enc
//  Purpose  : Control FSM for the AES-128 forward datapath with a
//             start/busy/done host handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module state_enc
    import state_enc_pkg::*;
#(
    parameter int unsigned NR = AES_NR
)(
    input  wire logic   clk,
    input  wire logic   res,
    state_enc_if.slave  bus
);

    localparam logic [7:0] C_NR = 8'(NR);

    state_t     cs_q;
    logic [7:0] cot_q;
    logic [7:0] rcon_w;
    logic       rcon_load_w;
    logic       rcon_adv_w;

    // Round counter advances on leaving ADD, so it stays constant across
    // the SUB/SHI/MIX/KEY/ADD sequence of one round.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cs_q  <= S_RES;
            cot_q <= 8'h00;
        end else begin
            case (cs_q)
                S_RES: begin
                    if (bus.start) begin
                        cs_q <= S_STL;
                    end
                end
                S_STL: begin
                    cot_q <= 8'h00;
                    cs_q  <= S_ADD;
                end
                S_ADD: begin
                    if (cot_q == C_NR) begin
                        cs_q <= S_FIN;
                    end else begin
                        cot_q <= cot_q + 8'h01;
                        cs_q  <= S_SUB;
                    end
                end
                S_SUB: begin
                    cs_q <= S_SHI;
                end
                S_SHI: begin
                    // Final round has no MixColumns.
                    if (cot_q == C_NR) begin
                        cs_q <= S_KEY;
                    end else begin
                        cs_q <= S_MIX;
                    end
                end
                S_MIX: begin
                    cs_q <= S_KEY;
                end
                S_KEY: begin
                    cs_q <= S_ADD;
                end
                S_FIN: begin
                    if (bus.start) begin
                        cs_q <= S_STL;
                    end
                end
                default: begin
                    cs_q <= S_RES;
                end
            endcase
        end
    end

    assign rcon_load_w = (cs_q == S_STL);
    assign rcon_adv_w  = (cs_q == S_KEY);

    aes_rcon_gen u_rcon_gen (
        .clk    (clk),
        .res    (res),
        .load_i (rcon_load_w),
        .adv_i  (rcon_adv_w),
        .rcon_o (rcon_w)
    );

    assign bus.cs   = cs_q;
    assign bus.cot  = cot_q;
    assign bus.rcon = rcon_w;
    assign bus.busy = (cs_q != S_RES) && (cs_q != S_FIN);
    assign bus.done = (cs_q == S_FIN);

endmodule : state_enc

`default_nettype wire
